// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: PC generation, pipelined read-address issue and a fetch queue.
// Define IFU_FQ_SBP_EN to enable static branch prediction on instructions entering the queue.
module ifu_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       FQ_DEPTH = 4,
    parameter int unsigned       MAX_OUTS = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_flag_i,
    input  logic [ADDR_W-1:0]         jump_addr_i,
    input  logic                      stall_pc_i,
    output logic                      ar_valid_o,
    output logic [ADDR_W-1:0]         ar_addr_o,
    input  logic                      ar_ready_i,
    input  logic                      r_valid_i,
    input  logic [DATA_W-1:0]         r_data_i,
    output logic                      r_ready_o,
    output logic [DATA_W-1:0]         inst_o,
    output logic [ADDR_W-1:0]         inst_addr_o,
    output logic                      inst_valid_o,
    input  logic                      inst_ready_i,
    output logic                      pred_taken_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

    logic [ADDR_W-1:0] pc_q, pc_d, ar_addr_q, ar_addr_d;
    logic              ar_valid_q, ar_valid_d, stale_q, stale_d;
    logic [CW-1:0]     outs_q, outs_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     if_wr_q, if_wr_d, if_rd_q, if_rd_d;
    logic [ADDR_W-1:0] if_addr_q [MAX_OUTS];
    logic [DATA_W-1:0] fq_data_q [FQ_DEPTH];
    logic [ADDR_W-1:0] fq_addr_q [FQ_DEPTH];
    logic              fq_pred_q [FQ_DEPTH];

    logic              accept, resp, push, pop, credit, redirect, pred_taken;
    logic [ADDR_W-1:0] resp_addr, pred_target;
    logic [CW:0]       inflight_sum;

    assign accept    = ar_valid_q & ar_ready_i;
    assign resp      = r_valid_i;
    assign resp_addr = if_addr_q[if_rd_q];
    assign push      = resp & (drop_q == '0) & ~jump_flag_i;
    assign pop       = inst_ready_i & (count_q != '0) & ~jump_flag_i;
    assign redirect  = push & pred_taken & ~jump_flag_i;

`ifdef IFU_FQ_SBP_EN
    logic [20:0] imm_j;
    logic [12:0] imm_b;
    logic        is_jal, is_bneg;

    assign imm_j = {r_data_i[31], r_data_i[19:12], r_data_i[20], r_data_i[30:21], 1'b0};
    assign imm_b = {r_data_i[31], r_data_i[7], r_data_i[30:25], r_data_i[11:8], 1'b0};
    assign is_jal = (r_data_i[6:0] == 7'b1101111);
    // Backward branches are predicted taken (loop heuristic).
    assign is_bneg = (r_data_i[6:0] == 7'b1100011) & r_data_i[31];
    assign pred_taken = is_jal | is_bneg;
    assign pred_target = resp_addr + (is_jal ? {{(ADDR_W-21){imm_j[20]}}, imm_j}
                                             : {{(ADDR_W-13){imm_b[12]}}, imm_b});
`else
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    always_comb begin
        outs_d = outs_q;
        if (accept) outs_d = outs_d + CW'(1);
        if (resp)   outs_d = outs_d - CW'(1);

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (jump_flag_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_d + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_d - CW'(1);
            end
        end

        if_wr_d = if_wr_q;
        if_rd_d = if_rd_q;
        if (accept) if_wr_d = (if_wr_q == OW'(MAX_OUTS - 1)) ? '0 : if_wr_q + OW'(1);
        if (resp)   if_rd_d = (if_rd_q == OW'(MAX_OUTS - 1)) ? '0 : if_rd_q + OW'(1);

        // A redirect owes every response still outstanding after this cycle.
        drop_d = drop_q;
        if (resp && drop_q != '0)    drop_d = drop_d - CW'(1);
        if (accept && stale_q)       drop_d = drop_d + CW'(1);
        if (jump_flag_i || redirect) drop_d = outs_d;

        stale_d = stale_q;
        if (accept) stale_d = 1'b0;
        if ((jump_flag_i || redirect) && ar_valid_q && !ar_ready_i) stale_d = 1'b1;

        pc_d = pc_q;
        if (accept && !stale_q) pc_d = pc_q + ADDR_W'(4);
        if (redirect)           pc_d = pred_target;
        if (jump_flag_i)        pc_d = jump_addr_i;

        inflight_sum = {1'b0, outs_d} + {1'b0, count_d};
        credit = (outs_d < CW'(MAX_OUTS)) && (inflight_sum < (CW+1)'(FQ_DEPTH)) &&
                 !stall_pc_i && !jump_flag_i;

        ar_valid_d = 1'b0;
        ar_addr_d  = ar_addr_q;
        if (ar_valid_q && !ar_ready_i) begin
            ar_valid_d = 1'b1;
        end else if (credit) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ar_addr_q  <= RESET_PC;
            ar_valid_q <= 1'b0;
            stale_q    <= 1'b0;
            outs_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            if_wr_q    <= '0;
            if_rd_q    <= '0;
            for (int i = 0; i < int'(MAX_OUTS); i++) if_addr_q[i] <= '0;
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_data_q[i] <= '0;
                fq_addr_q[i] <= '0;
                fq_pred_q[i] <= 1'b0;
            end
        end else begin
            pc_q       <= pc_d;
            ar_addr_q  <= ar_addr_d;
            ar_valid_q <= ar_valid_d;
            stale_q    <= stale_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if_wr_q    <= if_wr_d;
            if_rd_q    <= if_rd_d;
            if (accept) if_addr_q[if_wr_q] <= ar_addr_q;
            if (push) begin
                fq_data_q[wr_ptr_q] <= r_data_i;
                fq_addr_q[wr_ptr_q] <= resp_addr;
                fq_pred_q[wr_ptr_q] <= pred_taken;
            end
        end
    end

    assign ar_valid_o   = ar_valid_q;
    assign ar_addr_o    = ar_addr_q;
    assign r_ready_o    = 1'b1;
    assign inst_o       = fq_data_q[rd_ptr_q];
    assign inst_addr_o  = fq_addr_q[rd_ptr_q];
    assign inst_valid_o = (count_q != '0);
    assign pred_taken_o = fq_pred_q[rd_ptr_q] & inst_valid_o;
    assign fq_count_o   = count_q;

    // The credit check must make a push into a full queue unreachable.
    assert property (@(posedge clk) disable iff (rst) push |-> (count_q < CW'(FQ_DEPTH)))
        else $error("fetch queue push while full");

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised next-generation instruction fetch front end.
- Generates the PC and issues in-order, pipelined AXI-style read-address requests with up to MAX_OUTS requests in flight.
- Buffers returned instructions, each with its fetch address, in a FQ_DEPTH-entry queue.
- Delivers them to decode over a valid/ready handshake. Redirects (jump) flush the queue and silently discard stale in-flight responses.

Parameters:
- ADDR_W, 32, PC/instruction address width.
- DATA_W, 32, instruction word width.
- FQ_DEPTH, 4, fetch queue entries; power of two, >=2.
- MAX_OUTS, 2, maximum outstanding read requests; 1..FQ_DEPTH.
- RESET_PC, 32'h8000_0000, PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- jump_flag_i  in  1  redirect request from execute.
- jump_addr_i  in  ADDR_W  redirect target.
- stall_pc_i  in  1  inhibit new request issue.
- ar_valid_o  out  1  read-address valid.
- ar_addr_o  out  ADDR_W  read address (current PC).
- ar_ready_i  in  1  read-address accepted.
- r_valid_i  in  1  read-data valid; responses return in issue order.
- r_data_i  in  DATA_W  instruction word.
- r_ready_o  out  1  tied to 1; credit scheme guarantees space.
- inst_o  out  DATA_W  head instruction.
- inst_addr_o  out  ADDR_W  head instruction address.
- inst_valid_o  out  1  queue non-empty.
- inst_ready_i  in  1  decode consumes head when valid.
- pred_taken_o  out  1  head was fetch-predicted taken (0 without the optional feature).
- fq_count_o  out  $clog2(FQ_DEPTH)+1  occupied entries.

Behaviour:
- Reset values: pc=RESET_PC, ar_valid_o=0, inst_valid_o=0, pred_taken_o=0, fq_count_o=0, outs=0, drop=0. Queue pointers are 0. inst_o and inst_addr_o are 0.
- Credit rule: a new request may be raised only if outs<MAX_OUTS, outs+fq_count<FQ_DEPTH, !stall_pc_i, and !jump_flag_i.
- AR handshake: once ar_valid_o=1, ar_valid_o and ar_addr_o hold stable until ar_ready_i. stall_pc_i and jump_flag_i never withdraw a pending request.
- On acceptance (ar_valid_o&ar_ready_i):
  - outs+=1.
  - The address is pushed into an in-flight address FIFO (depth MAX_OUTS).
  - pc advances to pc+4, or to the predicted target with the optional feature.
  - ar_valid_o may re-assert next cycle, which allows back-to-back requests.
- Response handling (r_valid_i):
  - outs-=1 and the in-flight address FIFO pops.
  - If drop>0: drop-=1 and the data is discarded.
  - Otherwise {r_data_i, popped addr} is written into the queue.
  - The response becomes visible on inst_o at the earliest the next cycle (1-cycle latency).
- Jump (1-cycle pulse):
  - The queue is emptied, so inst_valid_o=0 next cycle.
  - pc<=jump_addr_i.
  - drop is set to the number of responses still owed. That count includes a request accepted in the same cycle and excludes a response consumed in the same cycle.
  - If a request is pending and not accepted, it is accepted later and counted into drop at acceptance; pc is not overwritten by that acceptance.
  - Jump has priority over stall and prediction.
  - The first post-jump request is raised the cycle after the jump, or after the pending AR completes.
- Simultaneous push and pop on the queue: count is unchanged. Pop from an empty queue is ignored. The credit rule makes push to a full queue impossible, and an assertion checks this.
- Pointer wrap: $clog2(FQ_DEPTH)-bit pointers wrap naturally. count is held separately.
- pc arithmetic: modulo 2^ADDR_W; pc+4 wraps through zero.
- Reset mid-operation clears all state immediately. Responses for pre-reset requests are the interconnect's responsibility.

Optional Feature:
- Macro: IFU_FQ_SBP_EN.
- When defined, a static predictor is applied to each response written into the queue:
  - JAL (opcode 1101111): predicted taken.
  - B-type (1100011) with negative immediate: predicted taken.
  - Target = addr+imm.
- A taken prediction performs a redirect identical to jump, minus the queue flush. Younger in-flight responses are dropped via drop. pc<=target.
- pred_taken_o=1 accompanies that entry.
- If jump_flag_i occurs in the same cycle, jump wins.
- When undefined: no decode logic, pred_taken_o=0, sequential fetch only.

Test Plan:
- Reset release, ar_ready_i=1, memory returns 1-cycle responses -> ar_addr_o sequence 8000_0000, 8000_0004, 8000_0008…; inst_valid_o first high at cycle 3; fq_count_o saturates at 4 when inst_ready_i=0.
- ar_ready_i=0 for 5 cycles with jump pulse to 8000_0100 at cycle 2 -> ar_addr_o stays 8000_0000 until accepted; its response is dropped; the next request is 8000_0100.
- MAX_OUTS=2, two requests in flight, jump to 8000_0200 -> both responses discarded; the first inst_addr_o after the jump is 8000_0200.
- Queue full (4) with inst_ready_i toggling 1/0 -> no push when count=4; the order of inst_addr_o is strictly +4 with no loss or duplication.
- pc=FFFF_FFFC, sequential fetch -> next ar_addr_o is 0000_0000.
- With IFU_FQ_SBP_EN, response BEQ imm=-8 at 8000_0010 -> pred_taken_o=1 on that entry; next ar_addr_o is 8000_0008; the younger in-flight response is dropped.
